sine_osc: RTL and testbench

SINE_OSC -- requirements
Module: sine_osc

---
 rtl/sine_osc.sv | 108 ++++++++++
 tb/tb_sine_osc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sine_osc.sv
// Table-lookup sine oscillator: phase accumulator, 512-entry half-word ROM fetch, valid/ready sample output.
// Optional macro SINE_OSC_SIGNED_OUT_EN selects two's-complement output instead of offset binary.
module sine_osc #(
  parameter int PHASE_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               tick,
  input  logic [PHASE_W-1:0] fcw,
  output logic               rom_en,
  output logic [7:0]         rom_addr,
  input  logic [15:0]        rom_dout,
  output logic [7:0]         sample,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  input  logic               overrun_clr
);

`ifdef SINE_OSC_SIGNED_OUT_EN
  localparam logic [7:0] SAMPLE_RST = 8'h00;
  localparam logic [7:0] SAMPLE_FLIP = 8'h80;
`else
  localparam logic [7:0] SAMPLE_RST = 8'h80;
  localparam logic [7:0] SAMPLE_FLIP = 8'h00;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CAPT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase;
  logic [8:0]         idx_lat;
  logic               tick_run;
  logic               accept;
  logic               drop;
  logic [7:0]         sel_byte;

  assign tick_run = tick & run;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (tick_run) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ:  state_nxt = CAPT;
      CAPT:  state_nxt = VALID;
      VALID: begin
        // A tick landing on the transfer cycle starts the next fetch directly.
        if (sample_ready) begin
          if (tick_run) begin
            accept    = 1'b1;
            state_nxt = READ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign drop         = tick_run & ~accept;
  assign rom_en       = (state == READ);
  assign rom_addr     = idx_lat[8:1];
  assign sample_valid = (state == VALID);
  assign sel_byte     = idx_lat[0] ? rom_dout[15:8] : rom_dout[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      idx_lat <= '0;
      sample  <= SAMPLE_RST;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      // Phase keeps advancing on dropped ticks so frequency stays exact.
      if (!run) begin
        phase <= '0;
      end else if (tick) begin
        phase <= phase + fcw;
      end
      if (accept) begin
        idx_lat <= phase[PHASE_W-1 -: 9];
      end
      if (state == CAPT) begin
        sample <= sel_byte ^ SAMPLE_FLIP;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_osc.sv
// Directed bench for sine_osc with a registered ROM stub returning {addr, ~addr}.
// Honours SINE_OSC_SIGNED_OUT_EN when computing expected samples.
module tb_sine_osc;

  logic        clk;
  logic        rst;
  logic        run;
  logic        tick;
  logic [23:0] fcw;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        overrun_clr;

  int n_checks = 0;
  int n_fail   = 0;

  sine_osc #(.PHASE_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .tick         (tick),
    .fcw          (fcw),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) begin
    if (rom_en) rom_dout <= {rom_addr, ~rom_addr};
  end

  function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef SINE_OSC_SIGNED_OUT_EN
    return b ^ 8'h80;
`else
    return b;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Tick, then check READ, CAPT and VALID cycles; leaves the DUT in VALID.
  task automatic fetch(input string tag, input logic [7:0] a, input logic [7:0] s);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk({tag, "_rom_en"}, rom_en, 1'b1);
    chk({tag, "_rom_addr"}, rom_addr, a);
    chk({tag, "_vld_read"}, sample_valid, 1'b0);
    step();
    chk({tag, "_rom_en_capt"}, rom_en, 1'b0);
    chk({tag, "_vld_capt"}, sample_valid, 1'b0);
    step();
    chk({tag, "_vld"}, sample_valid, 1'b1);
    chk({tag, "_sample"}, sample, s);
  endtask

  initial begin
    rst          = 1'b1;
    run          = 1'b0;
    tick         = 1'b0;
    fcw          = 24'h0;
    sample_ready = 1'b0;
    overrun_clr  = 1'b0;
    #1;
    chk("rst_rom_en", rom_en, 1'b0);
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_vld", sample_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_sample", sample, exp_byte(8'h80));
    step();
    rst = 1'b0;
    step();

    // Basic sweep: idx 0..3 at one table step per tick.
    fcw = 24'h008000;
    run = 1'b1;
    sample_ready = 1'b1;
    fetch("sw0", 8'h00, exp_byte(8'hFF));
    step();
    chk("sw0_done_vld", sample_valid, 1'b0);
    chk("sw0_retain", sample, exp_byte(8'hFF));
    repeat (4) step();
    fetch("sw1", 8'h00, exp_byte(8'h00));
    repeat (5) step();
    fetch("sw2", 8'h01, exp_byte(8'hFE));
    repeat (5) step();
    fetch("sw3", 8'h01, exp_byte(8'h01));
    repeat (5) step();

    // Backpressure: held sample, dropped ticks, overrun behaviour.
    do_reset();
    sample_ready = 1'b0;
    fetch("bp0", 8'h00, exp_byte(8'hFF));
    repeat (5) step();
    chk("bp_hold_vld", sample_valid, 1'b1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("bp_ovr_set", overrun, 1'b1);
    chk("bp_drop_no_rom", rom_en, 1'b0);
    chk("bp_hold_sample", sample, exp_byte(8'hFF));
    repeat (7) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("bp_phase", dut.phase, 24'h018000);
    chk("bp_hold_vld2", sample_valid, 1'b1);
    overrun_clr = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("ovr_clr_vs_set", overrun, 1'b1);
    step();
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);

    // Tick coincident with transfer: phase 0x020000 -> idx 4.
    sample_ready = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("co_vld_drop", sample_valid, 1'b0);
    chk("co_rom_en", rom_en, 1'b1);
    chk("co_rom_addr", rom_addr, 8'h02);
    chk("co_no_ovr", overrun, 1'b0);
    step();
    step();
    chk("co_vld", sample_valid, 1'b1);
    chk("co_sample", sample, exp_byte(8'hFD));
    step();

    // run dropped mid-fetch: idx 5 still delivered, phase cleared, later ticks ignored.
    tick = 1'b1;
    step();
    tick = 1'b0;
    run = 1'b0;
    chk("run_rom_addr", rom_addr, 8'h02);
    step();
    chk("run_phase0", dut.phase, 24'h0);
    step();
    chk("run_vld", sample_valid, 1'b1);
    chk("run_sample", sample, exp_byte(8'h02));
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("run_off_ignored", rom_en, 1'b0);
    run = 1'b1;
    step();

    // Phase wrap: fcw 0xFF8000 gives idx 0 then 511 (hi byte of {0xFF,0x00}).
    do_reset();
    fcw = 24'hFF8000;
    fetch("wr0", 8'h00, exp_byte(8'hFF));
    step();
    fetch("wr1", 8'hFF, exp_byte(8'hFF));
    step();

    // Reset while in CAPT discards the fetch.
    do_reset();
    fcw = 24'h008000;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_rom_en", rom_en, 1'b0);
    chk("mid_rst_addr", rom_addr, 8'h00);
    chk("mid_rst_vld", sample_valid, 1'b0);
    chk("mid_rst_sample", sample, exp_byte(8'h80));
    chk("mid_rst_phase", dut.phase, 24'h0);
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("post_rst_no_vld", sample_valid, 1'b0);
    fetch("post", 8'h00, exp_byte(8'hFF));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
